// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control stage.
// Latency: none (declarations only).
// Backpressure: none.
package stopwatch_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} sw_state_t;

    // Defaults for a 100 MHz clock: 1 ms tick, 200 us debounce window.
    localparam int SW_DIV        = 100000;
    localparam int SW_DEB_CYCLES = 20000;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
// Latency: level/press change DEB_CYCLES+2 cycles after a stable raw change.
// Backpressure: none; press is a one-cycle pulse per accepted rising level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = SW_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, then count consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                // Any agreeing sample breaks the run, so the window restarts.
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch control: debounced buttons, IDLE/RUN/PAUSE FSM, tick prescaler, clear pulse.
// Latency: FSM moves one cycle after a press; outputs are registered.
// Backpressure: none. Optional lap-hold feature under macro STOPWATCH_LAP_HOLD_EN.
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV        = SW_DIV,
    parameter int DEB_CYCLES = SW_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_clear,
    input  logic btn_lap,
    output logic tick,
    output logic clear_cnt,
    output logic running,
    output logic lap_hold
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic          start_press;
    logic          clear_press;
    logic          unused_start_level;
    logic          unused_clear_level;

    sw_state_t     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          clr_d;
    logic          tick_q;
    logic          clear_q;
    logic          running_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_start),
        .level (unused_start_level),
        .press (start_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .level (unused_clear_level),
        .press (clear_press)
    );

    // Next state and prescaler; clear has priority over start outside RUN.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        clr_d   = 1'b0;
        if (state_q == ST_RUN) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
        case (state_q)
            ST_RUN: begin
                if (start_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_IDLE, ST_PAUSE: begin
                if (clear_press) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_press) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            pre_d = '0;
        end
    end

    // State, prescaler and registered outputs; tick is looked ahead so it coincides with count DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= (state_d == ST_RUN) && (pre_d == PRE_LAST);
            clear_q   <= clr_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign tick      = tick_q;
    assign clear_cnt = clear_q;
    assign running   = running_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic lap_press;
    logic unused_lap_level;
    logic lap_q, lap_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_lap),
        .level (unused_lap_level),
        .press (lap_press)
    );

    // Lap toggles only while running; returning to IDLE drops the freeze.
    always_comb begin
        lap_d = lap_q;
        if ((state_q == ST_RUN) && lap_press) begin
            lap_d = ~lap_q;
        end
        if (state_d == ST_IDLE) begin
            lap_d = 1'b0;
        end
    end

    // Lap-hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_hold = lap_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Self-checking bench for stopwatch_tick_ctrl with DIV=10, DEB_CYCLES=4.
// Reference model: delay line plus "last DEB samples agree" window, FSM rules, modulo prescaler.
// Inputs driven and outputs sampled on the falling edge.
module tb_stopwatch_tick_ctrl;

    localparam int DIV = 10;
    localparam int DEB = 4;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam logic LAP_EXP = 1'b1;
`else
    localparam logic LAP_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic btn_lap = 1'b0;
    logic tick, clear_cnt, running, lap_hold;

    int checks = 0;
    int errors = 0;

    stopwatch_tick_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .tick      (tick),
        .clear_cnt (clear_cnt),
        .running   (running),
        .lap_hold  (lap_hold)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_p1 [3];
    int         m_p2 [3];
    int         m_hist [3][DEB];
    int         m_lvl [3];
    int         m_press [3];
    int         m_st;      // 0 idle, 1 run, 2 pause
    int         m_pre;
    int         m_lap;
    int         m_clr;
    logic [3:0] m_exp = 4'b0;

    always @(posedge clk) begin
        int raw [3];
        bit same;
        raw[0] = int'(btn_start);
        raw[1] = int'(btn_clear);
        raw[2] = int'(btn_lap);
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_p1[b] = 0; m_p2[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
                for (int k = 0; k < DEB; k++) m_hist[b][k] = 0;
            end
            m_st = 0; m_pre = 0; m_lap = 0; m_clr = 0;
        end else begin
            // FSM reacts to presses that were visible during the previous cycle
            m_clr = 0;
            if (m_st == 1) m_pre = (m_pre + 1) % DIV;
            if (m_st == 1) begin
                if (m_press[0] != 0) m_st = 2;
                if (m_press[2] != 0) m_lap = 1 - m_lap;
            end else if (m_press[1] != 0) begin
                m_st = 0;
                m_clr = 1;
            end else if (m_press[0] != 0) begin
                m_st = 1;
            end
            if (m_st == 0) begin
                m_pre = 0;
                m_lap = 0;
            end
            // Buttons: synced sample = raw from two edges ago; accept when last DEB samples agree
            for (int b = 0; b < 3; b++) begin
                for (int k = DEB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = m_p2[b];
                m_p2[b] = m_p1[b];
                m_p1[b] = raw[b];
                same = 1'b1;
                for (int k = 1; k < DEB; k++) if (m_hist[b][k] != m_hist[b][0]) same = 1'b0;
                m_press[b] = 0;
                if (same && (m_hist[b][0] != m_lvl[b])) begin
                    m_lvl[b] = m_hist[b][0];
                    m_press[b] = m_lvl[b];
                end
            end
        end
        m_exp[3] = (m_st == 1) && (m_pre == DIV - 1);
        m_exp[2] = (m_clr != 0);
        m_exp[1] = (m_st == 1);
`ifdef STOPWATCH_LAP_HOLD_EN
        m_exp[0] = (m_lap != 0);
`else
        m_exp[0] = 1'b0;
`endif
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b want 0000", i, {tick, clear_cnt, running, lap_hold});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== 4'b0000 ||
                {tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b want 0000 model %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
        end
    endtask

    task automatic test_short_press();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL short_press cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            btn_start = (i < 3);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL short_press_idle got running=%b want 0", running);
        end
    endtask

    task automatic test_start_run();
        int r0 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL start_run cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            if (r0 < 0 && running === 1'b1) r0 = i;
            if (r0 >= 0 && (i - r0) < 35) begin
                checks++;
                if (tick !== (((i - r0) % DIV) == DIV - 1)) begin
                    errors++;
                    $display("FAIL tick_spacing run+%0d got tick=%b want %b", i - r0, tick, (((i - r0) % DIV) == DIV - 1));
                end
            end
            btn_start = (i < 10);
        end
        checks++;
        if (r0 < 0) begin
            errors++;
            $display("FAIL start_never_ran got running=0 want 1");
        end
    endtask

    task automatic test_pause();
        bit found = 1'b0;
        int r1 = -1;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL pause_wait cyc %0d got %b want %b", w, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            if (m_pre == 0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pause_wait_timeout got no prescaler 0 want within 40 cycles");
        end
        // Raised now, the press lands with the prescaler at 6.
        btn_start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL pause cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            if (i >= 8 && i < 48) begin
                checks++;
                if ({tick, running} !== 2'b00) begin
                    errors++;
                    $display("FAIL pause_quiet cyc %0d got tick,running=%b want 00", i, {tick, running});
                end
            end
            if (i >= 48 && r1 < 0 && running === 1'b1) r1 = i;
            if (r1 >= 0 && (i - r1) < 15) begin
                checks++;
                if (tick !== ((i - r1) == 2 || (i - r1) == 12)) begin
                    errors++;
                    $display("FAIL resume_tick run+%0d got tick=%b want %b", i - r1, tick, ((i - r1) == 2 || (i - r1) == 12));
                end
            end
            btn_start = (i < 7) || (i >= 47 && i < 55);
        end
        checks++;
        if (r1 < 0) begin
            errors++;
            $display("FAIL resume_never_ran got running=0 want 1");
        end
    endtask

    task automatic test_clear();
        bit seg_s [6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bit seg_c [6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit exp_run [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int exp_clr [6] = '{0, 0, 1, 0, 0, 1};
        for (int s = 0; s < 6; s++) begin
            int pulses = 0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                checks++;
                if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                    errors++;
                    $display("FAIL clear seg %0d cyc %0d got %b want %b", s, i, {tick, clear_cnt, running, lap_hold}, m_exp);
                end
                if (clear_cnt === 1'b1) pulses++;
                btn_start = seg_s[s] && (i < 8);
                btn_clear = seg_c[s] && (i < 8);
            end
            checks++;
            if (running !== exp_run[s] || pulses != exp_clr[s]) begin
                errors++;
                $display("FAIL clear_seg %0d got running=%b pulses=%0d want running=%b pulses=%0d", s, running, pulses, exp_run[s], exp_clr[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL reset_mid_start cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            btn_start = (i < 8);
        end
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (m_st == 1 && m_pre == 7) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_timeout got no prescaler 7 in RUN want within 40 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({tick, clear_cnt, running, lap_hold} !== 4'b0000 || m_exp !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got %b model %b want 0000", {tick, clear_cnt, running, lap_hold}, m_exp);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d got %b want 0000", i, {tick, clear_cnt, running, lap_hold});
            end
        end
    endtask

    task automatic test_lap();
        int r0 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL lap cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            if (r0 < 0 && running === 1'b1) r0 = i;
            if (r0 >= 0) begin
                checks++;
                if (tick !== (((i - r0) % DIV) == DIV - 1)) begin
                    errors++;
                    $display("FAIL lap_ticks run+%0d got tick=%b want %b", i - r0, tick, (((i - r0) % DIV) == DIV - 1));
                end
            end
            btn_start = (i < 8);
            btn_lap   = (i < 8) || (i >= 15 && i < 23);
        end
        checks++;
        if (lap_hold !== LAP_EXP) begin
            errors++;
            $display("FAIL lap_toggle got lap_hold=%b want %b", lap_hold, LAP_EXP);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        logic [2:0] b = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({tick, clear_cnt, running, lap_hold} !== m_exp) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, {tick, clear_cnt, running, lap_hold}, m_exp);
            end
            checks++;
            if (tick === 1'b1 && clear_cnt === 1'b1) begin
                errors++;
                $display("FAIL tick_clear_overlap cyc %0d got 11 want not both", i);
            end
            if (hold == 0) begin
                b = 3'($urandom);
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            btn_start = b[0];
            btn_clear = b[1];
            btn_lap   = b[2];
            reset     = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_start_run();
        test_pause();
        test_clear();
        test_reset_mid();
        test_lap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
